// File: rtl/alu_cmd_stage.sv
// alu_cmd_stage: FIFO-buffered command issue stage for a combinational 8-bit ALU,
// with a valid/ready result register and result chaining into operand x.
module alu_cmd_stage #(
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [3:0] in_ctrl,
    input  logic [7:0] in_x,
    input  logic [7:0] in_y,
    input  logic       in_chain,
    output logic [3:0] alu_ctrl,
    output logic [7:0] alu_x,
    output logic [7:0] alu_y,
    input  logic       alu_carry,
    input  logic [7:0] alu_out,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       out_carry,
    output logic [7:0] out_data,
    output logic [3:0] out_ctrl
);
    typedef enum logic [1:0] {IDLE, EXEC, WAIT} state_t;
    state_t        r_state, w_next;
    logic [20:0]   r_mem [DEPTH];
    logic [AW-1:0] r_wr, r_rd;
    logic [AW:0]   r_cnt;
    logic [7:0]    r_acc;
    logic [20:0]   w_head;
    logic          w_push, w_pop, w_capture, w_out_free, w_busy;

    assign w_head     = r_mem[r_rd];
    assign in_ready   = r_cnt < (AW+1)'(DEPTH);
    assign w_push     = in_valid & in_ready;
    assign w_out_free = !out_valid | out_ready;
    assign w_busy     = r_state != IDLE;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;

    always_comb
        w_next = (!w_busy || w_out_free) ? (|r_cnt ? EXEC : IDLE) : WAIT;

    always_comb begin
        w_capture = w_busy & w_out_free;
        w_pop     = |r_cnt & (!w_busy | w_capture);
    end

    always_ff @(posedge clk)
        if (w_push) r_mem[r_wr] <= {in_chain, in_ctrl, in_x, in_y};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr      <= '0;
            r_rd      <= '0;
            r_cnt     <= '0;
            r_acc     <= '0;
            alu_ctrl  <= '0;
            alu_x     <= '0;
            alu_y     <= '0;
            out_valid <= 1'b0;
            out_carry <= 1'b0;
            out_data  <= '0;
            out_ctrl  <= '0;
        end else begin
            if (w_push) r_wr <= r_wr + 1'b1;
            if (w_push != w_pop) r_cnt <= w_push ? r_cnt + 1'b1 : r_cnt - 1'b1;
            if (w_pop) begin
                r_rd     <= r_rd + 1'b1;
                alu_ctrl <= w_head[19:16];
                // a chained command loaded on a capture edge must see the result being captured
                alu_x    <= w_head[20] ? (w_capture ? alu_out : r_acc) : w_head[15:8];
                alu_y    <= w_head[7:0];
            end
            if (w_capture) begin
                out_valid <= 1'b1;
                out_carry <= alu_carry;
                out_data  <= alu_out;
                out_ctrl  <= alu_ctrl;
                r_acc     <= alu_out;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_alu_cmd_stage.sv
// tb_alu_cmd_stage: directed bench with the team ALU and an in-order result scoreboard.
module tb_alu_cmd_stage;
    typedef struct packed {logic c; logic [7:0] d; logic [3:0] op;} res_t;

    logic       clk = 1'b0;
    logic       rst_n, in_valid, in_ready, in_chain, alu_carry, out_valid, out_ready, out_carry;
    logic [3:0] in_ctrl, alu_ctrl, out_ctrl;
    logic [7:0] in_x, in_y, alu_x, alu_y, alu_out, out_data;

    res_t       q[$];
    res_t       m_exp;
    logic [8:0] m_res;
    logic [7:0] m_acc;
    int         n_chk = 0, n_pass = 0, n_acc = 0, n_res = 0, acc0;

    alu_cmd_stage #(.DEPTH(4), .AW(2)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_ctrl(in_ctrl), .in_x(in_x), .in_y(in_y), .in_chain(in_chain),
        .alu_ctrl(alu_ctrl), .alu_x(alu_x), .alu_y(alu_y),
        .alu_carry(alu_carry), .alu_out(alu_out),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_carry(out_carry), .out_data(out_data), .out_ctrl(out_ctrl)
    );

    always #5 clk = ~clk;

    function automatic logic [8:0] alu_f(input logic [3:0] op, input logic [7:0] x, input logic [7:0] y);
        return (op == 4'd0) ? {1'b0, x} + {1'b0, y} : {1'b0, x & y};
    endfunction

    always_comb {alu_carry, alu_out} = alu_f(alu_ctrl, alu_x, alu_y);

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        assert (got === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic ch, input logic [7:0] x, input logic [7:0] y);
        in_valid = v;
        in_chain = ch;
        in_ctrl  = 4'd0;
        in_x     = x;
        in_y     = y;
    endtask

    // scoreboard: accepted commands push their expected result; handshakes pop and compare
    initial forever begin
        @(negedge clk);
        if (rst_n && in_valid && in_ready) begin
            m_res = alu_f(in_ctrl, in_chain ? m_acc : in_x, in_y);
            q.push_back({m_res[8], m_res[7:0], in_ctrl});
            m_acc = m_res[7:0];
            n_acc++;
        end
        if (rst_n && out_valid && out_ready) begin
            chk("sb_expected", q.size() != 0, 1);
            if (q.size() != 0) begin
                m_exp = q.pop_front();
                chk("sb_result", {out_carry, out_data, out_ctrl}, m_exp);
                n_res++;
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        m_acc = '0;
        out_ready = 1'b0;
        drive(1'b0, 1'b0, 8'h00, 8'h00);
        #2;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_alu", {alu_ctrl, alu_x, alu_y}, 0);
        tick();
        rst_n = 1'b1;
        // single op
        out_ready = 1'b1;
        drive(1'b1, 1'b0, 8'h7F, 8'h01);
        tick();
        in_valid = 1'b0;
        tick();
        chk("single_e2_valid", out_valid, 0);
        tick();
        chk("single_e3_valid", out_valid, 1);
        chk("single_e3_result", {out_carry, out_data, out_ctrl}, {1'b0, 8'h80, 4'h0});
        tick();
        chk("single_e4_valid", out_valid, 0);
        // back-to-back
        for (int i = 1; i <= 6; i++) begin
            drive(i <= 4, 1'b0, 8'(i), 8'h10);
            if (i <= 4) chk("b2b_in_ready", in_ready, 1);
            tick();
            if (i >= 3) begin
                chk("b2b_valid", out_valid, 1);
                chk("b2b_data", out_data, 8'h10 + i - 2);
            end
        end
        in_valid = 1'b0;
        tick();
        chk("b2b_done", out_valid, 0);
        // backpressure
        out_ready = 1'b0;
        acc0 = n_acc;
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 1'b0, 8'(8'h20 + i), 8'h01);
            tick();
        end
        in_valid = 1'b0;
        chk("bp_accepted", n_acc - acc0, 6);
        chk("bp_in_ready", in_ready, 0);
        chk("bp_hold", {out_valid, out_data}, {1'b1, 8'h21});
        out_ready = 1'b1;
        tick();
        chk("bp_in_ready_back", in_ready, 1);
        for (int i = 0; i < 5; i++) begin
            chk("bp_drain_valid", out_valid, 1);
            tick();
        end
        chk("bp_drain_done", out_valid, 0);
        chk("bp_queue_empty", q.size(), 0);
        // chain with forwarding, then chain from idle accumulator
        drive(1'b1, 1'b0, 8'hFF, 8'h01);
        tick();
        drive(1'b1, 1'b1, 8'h55, 8'h02);
        tick();
        in_valid = 1'b0;
        tick();
        chk("chain_first", {out_carry, out_data}, {1'b1, 8'h00});
        tick();
        chk("chain_fwd", {out_carry, out_data}, {1'b0, 8'h02});
        repeat (5) tick();
        drive(1'b1, 1'b1, 8'hAA, 8'h03);
        tick();
        in_valid = 1'b0;
        tick();
        chk("chain_idle_alu_x", alu_x, 8'h02);
        tick();
        chk("chain_idle", {out_valid, out_data}, {1'b1, 8'h05});
        tick();
        // reset mid-operation
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b0, 8'(8'h40 + i), 8'h00);
            tick();
        end
        in_valid = 1'b0;
        tick();
        rst_n = 1'b0;
        q.delete();
        m_acc = '0;
        #1;
        chk("mid_rst_out", {out_valid, out_carry, out_data, out_ctrl}, 0);
        chk("mid_rst_alu", {alu_ctrl, alu_x, alu_y}, 0);
        chk("mid_rst_in_ready", in_ready, 1);
        #2;
        rst_n = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("post_rst_quiet", out_valid, 0);
        end
        drive(1'b1, 1'b0, 8'h20, 8'h05);
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        chk("post_rst_fresh", {out_valid, out_data}, {1'b1, 8'h25});
        tick();
        chk("end_queue_empty", q.size(), 0);
        chk("end_result_count", n_res, 15);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/alu_cmd_stage.md
Name: alu_cmd_stage

Overview:
- Command issue stage that sits directly upstream of the team's combinational 8-bit ALU (ctrl[3:0], x[7:0], y[7:0] -> carry, out[7:0]).
- Buffers incoming {ctrl, x, y} commands in a small FIFO and drives them one per cycle onto registered ALU inputs.
- Captures the ALU's carry and out into a result register, presented downstream with valid/ready.
- Supports chaining: x is replaced by the previous result.

Parameters:
- DEPTH, 4, command FIFO entries (power of 2, at least 2).
- AW, 2, FIFO pointer width, equal to log2(DEPTH).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  command offered.
- in_ready  out  1  FIFO can accept.
- in_ctrl  in  4  ALU opcode (opaque to this block).
- in_x  in  8  operand x.
- in_y  in  8  operand y.
- in_chain  in  1  1 = use last result as x; in_x is ignored.
- alu_ctrl  out  4  registered ALU opcode.
- alu_x  out  8  registered ALU operand x.
- alu_y  out  8  registered ALU operand y.
- alu_carry  in  1  ALU carry, combinational from alu_*.
- alu_out  in  8  ALU result, combinational from alu_*.
- out_valid  out  1  result available.
- out_ready  in  1  downstream accepts.
- out_carry  out  1  captured carry.
- out_data  out  8  captured result.
- out_ctrl  out  4  opcode that produced the result.

Behaviour:
- Reset (async, rst_n=0): FIFO empty; in_ready=1; alu_ctrl/alu_x/alu_y=0; out_valid=0; out_carry=0; out_data=0; out_ctrl=0; acc=0; state=IDLE. Reset mid-operation discards all queued and in-flight commands. No output is produced for them after release.
- FIFO:
  - push = in_valid & in_ready.
  - in_ready = (count < DEPTH). It does not account for a same-cycle pop, so a full FIFO refuses input even while popping.
  - Pointers wrap modulo DEPTH.
  - count holds on simultaneous push and pop.
- out_free = !out_valid | out_ready.
- States:
  - IDLE: ALU inputs hold their last values. If the FIFO is non-empty: pop the head, load alu_* from it, go to EXEC.
  - EXEC: ALU inputs are stable for the full cycle.
    - If out_free: capture {alu_carry, alu_out, alu_ctrl} into the out register, set out_valid=1, set acc=alu_out.
    - In that same edge, if the FIFO is non-empty, pop and load the next command and stay in EXEC; otherwise go to IDLE.
    - If !out_free: go to WAIT; alu_* hold.
  - WAIT: alu_* hold; ALU output is re-evaluated each cycle. When out_free, capture exactly as in EXEC, with the same pop/IDLE decision.
- When out_valid & out_ready and no capture occurs in that edge, out_valid goes to 0.
- Chaining: when a command with chain=1 is loaded, alu_x is set as follows.
  - If a capture happens in the same edge, alu_x = alu_out (forwarded).
  - Otherwise alu_x = acc.
  - acc persists across IDLE and updates only on capture.
- Latency and throughput:
  - A command pushed at edge N into an empty, idle block is loaded at edge N+1 and captured at edge N+2.
  - out_valid is therefore 1 after edge N+2.
  - Sustained throughput is 1 result/cycle while out_ready=1.
- Ordering: results leave strictly in command order. None are dropped or duplicated under any backpressure pattern.
- Capacity under full stall: DEPTH in FIFO + 1 in EXEC/WAIT + 1 in the out register. With DEPTH=4, 6 commands are accepted before in_ready falls.
- Outputs are stable while out_valid=1 and out_ready=0.

Test Plan (bench includes the team ALU; ctrl 0000 = add):
- Single op: push {0000, 8'h7F, 8'h01} at edge 1, out_ready=1 -> out_valid=1 after edge 3, out_data=8'h80, out_carry=0, out_ctrl=0000; out_valid=0 after edge 4.
- Back-to-back: 4 pushes of {0000, i, 8'h10} for i=1..4 on consecutive edges, out_ready=1 -> results 8'h11, 8'h12, 8'h13, 8'h14 on 4 consecutive cycles; in_ready stays 1.
- Backpressure: out_ready=0, in_valid=1 continuously -> exactly 6 accepted; then in_ready=0. out_data holds the first result. With out_ready=1, all 6 drain in order, one per cycle; in_ready returns to 1 one cycle after the first pop.
- Chain forwarding: push {0000, 8'hFF, 8'h01} then {0000, chain=1, x=8'h55, y=8'h02} back-to-back -> results {carry=1, 8'h00}, then {carry=0, 8'h02}. The second must not use 8'h55 or the stale acc.
- Chain after idle: after the prior test plus 5 idle cycles, push {0000, chain=1, y=8'h03} -> 8'h05.
- Reset mid-operation: 3 commands queued with out_ready=0; pulse rst_n low for 3 ns between edges -> all outputs 0 immediately, in_ready=1. After release, no stale results appear; a fresh command produces only its own result.
